// File: rtl/rv_mem_pkg.sv
// Shared funct3 codes, FSM encoding and defaults for the MEM-stage load/store unit.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic f3_is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    // Any code that is neither byte nor half is treated as a word access.
    function automatic logic f3_is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a bus read word and sign- or zero-extends it.
module load_extend
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [31:0] byte_sh;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        byte_sh = rdata_i >> {offset_i, 3'b000};
        b       = byte_sh[7:0];
        // Half accesses only look at offset[1]; a set offset[0] is ignored.
        h       = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    result_o = {{24{b[7]}}, b};
            F3_BU:   result_o = {24'h0, b};
            F3_H:    result_o = {{16{h[15]}}, h};
            F3_HU:   result_o = {16'h0, h};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ready bus master with stall, timeout and load extension.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BusErrM,
    output logic        MisalignM
);

    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        access;
    logic        misalign;
    logic [3:0]  live_be;
    logic [31:0] live_wdata;
    logic [1:0]  ext_off;
    logic [2:0]  ext_f3;
    logic [31:0] ext_data;

    // Gating with reset_n keeps every output low while reset is held, even with live inputs.
    assign access = (MemReadM | MemWriteM) & reset_n;

    always_comb begin
        if (f3_is_byte(Funct3M)) begin
            live_be    = 4'b0001 << ALUResultM[1:0];
            live_wdata = {24'h0, WriteDataM[7:0]} << {ALUResultM[1:0], 3'b000};
        end else if (f3_is_half(Funct3M)) begin
            live_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            live_wdata = {16'h0, WriteDataM[15:0]} << {ALUResultM[1], 4'b0000};
        end else begin
            live_be    = 4'b1111;
            live_wdata = WriteDataM;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (access) begin
            if (f3_is_half(Funct3M)) begin
                misalign = ALUResultM[0];
            end else if (!f3_is_byte(Funct3M)) begin
                misalign = (ALUResultM[1:0] != 2'b00);
            end
        end
    end
`else
    assign misalign = 1'b0;
`endif

    assign ext_off = (state_q == ST_IDLE) ? ALUResultM[1:0] : addr_q[1:0];
    assign ext_f3  = (state_q == ST_IDLE) ? Funct3M : f3_q;

    load_extend u_load_extend (
        .rdata_i  (mem_rdata),
        .offset_i (ext_off),
        .funct3_i (ext_f3),
        .result_o (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        f3_d      = f3_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        ReadDataM = 32'h0;
        StallM    = 1'b0;
        BusErrM   = 1'b0;
        MisalignM = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (misalign) begin
                    MisalignM = 1'b1;
                end else if (access) begin
                    mem_req   = 1'b1;
                    mem_we    = MemWriteM;
                    mem_addr  = {ALUResultM[31:2], 2'b00};
                    mem_be    = live_be;
                    mem_wdata = MemWriteM ? live_wdata : 32'h0;
                    if (mem_ready) begin
                        ReadDataM = MemWriteM ? 32'h0 : ext_data;
                    end else begin
                        StallM  = 1'b1;
                        addr_d  = ALUResultM;
                        be_d    = live_be;
                        wdata_d = MemWriteM ? live_wdata : 32'h0;
                        we_d    = MemWriteM;
                        f3_d    = Funct3M;
                        cnt_d   = 8'd0;
                        err_d   = 1'b0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = be_q;
                mem_wdata = wdata_q;
                StallM    = 1'b1;
                cnt_d     = cnt_q + 8'd1;
                if (mem_ready) begin
                    rdata_d = we_q ? 32'h0 : ext_data;
                    state_d = ST_RESP;
                end else if (cnt_d >= TimeoutLimit) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                ReadDataM = rdata_q;
                BusErrM   = err_q;
                err_d     = 1'b0;
                cnt_d     = 8'd0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            cnt_q   <= 8'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register.
- Consumes MemWriteM, MemReadM, Funct3M, ALUResultM and WriteDataM. Drives a req/ready data-memory bus with byte enables.
- Returns sign/zero-extended ReadDataM toward the MEM/WB register.
- Stalls the pipeline while a multi-cycle access is outstanding, and aborts hung accesses with a timeout.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in WAIT before the access is aborted with a bus error (range 1..255)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
MemReadM  input  1  load in MEM stage
MemWriteM  input  1  store in MEM stage
Funct3M  input  3  access size/sign (RV32I encoding)
ALUResultM  input  32  effective byte address
WriteDataM  input  32  store data, right-justified
mem_req  output  1  bus request
mem_we  output  1  bus write strobe
mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
mem_be  output  4  byte enables
mem_wdata  output  32  lane-shifted store data
mem_ready  input  1  bus completion
mem_rdata  input  32  bus read word
ReadDataM  output  32  extended load result
StallM  output  1  freeze PC, IF/ID, ID/EX and EX/MEM
BusErrM  output  1  one-cycle pulse: access timed out
MisalignM  output  1  one-cycle pulse: misaligned access (feature only; otherwise tied 0)

Behaviour:
- Access request: access = MemReadM | MemWriteM.
  - Both MemReadM and MemWriteM high: treat as a store.
- Funct3M decode:
  - 000 = byte, 001 = half, 010 = word.
  - 100 = unsigned byte, 101 = unsigned half.
  - 011/110/111 = word.
- Store lanes: byte mem_be = 1<<addr[1:0]; half mem_be = 0011 or 1100 by addr[1]; word mem_be = 1111. mem_wdata = data replicated/shifted into the selected lanes.
- Load extend: select lane(s) of the read word by addr[1:0], then sign- or zero-extend.
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - When access is asserted, mem_req is driven combinationally from the live inputs.
  - mem_ready high in the same cycle: zero-wait completion. StallM = 0. ReadDataM is taken combinationally from mem_rdata. State stays IDLE.
  - mem_ready low: latch addr, be, wdata, we and funct3 into registers. Go to WAIT. StallM = 1.
- WAIT:
  - mem_req = 1 and the bus outputs come from the latched registers. StallM = 1.
  - The timeout counter increments every cycle.
  - On mem_ready: capture the extended rdata into a register and go to RESP.
  - Counter reaches TIMEOUT_CYCLES without mem_ready: drop mem_req, load 0 into the data register, set the bus-error flag and go to RESP.
  - mem_ready and timeout in the same cycle: mem_ready wins.
- RESP:
  - Lasts exactly one cycle, then returns to IDLE.
  - StallM = 0 and mem_req = 0.
  - ReadDataM comes from the captured register. BusErrM pulses in this cycle if the access timed out.
  - New requests are not accepted in RESP; the next instruction arrives in the following cycle.
- Latency: 0 extra cycles if mem_ready arrives in the request cycle; otherwise N wait cycles + 1 RESP cycle.
- No access in IDLE: mem_req = 0, mem_be = 0, StallM = 0, ReadDataM = 0.
- mem_ready outside an active request: ignored.
- Reset values: every output is 0 and the counter is 0. Reset asserted mid-WAIT forces IDLE immediately and mem_req falls asynchronously.
- Misaligned access (half with addr[0] = 1; word with addr[1:0] != 0) without the feature: performed with the offending low bits treated as 0 for lane selection.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access issues no bus request: mem_req = 0 and StallM = 0.
  - MisalignM pulses 1 for that cycle and ReadDataM = 0.
  - The FSM stays in IDLE.
- Undefined: MisalignM is tied 0 and the low-bit masking behaviour above applies.

Decomposition:
- Package rv_mem_pkg holds:
  - Funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding: ST_IDLE, ST_WAIT, ST_RESP.
  - Default TIMEOUT_CYCLES.
- One combinational sub-module, load_extend, handles lane select plus sign/zero extension (rdata, offset, funct3 -> 32-bit result).
- The FSM, store lane shifting and timeout counter stay in mem_access_unit.

Test Plan:
- Zero-wait SW: addr=0x100, data=0xDEADBEEF, mem_ready=1 in the same cycle -> mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF, StallM never asserted.
- SB with 3-cycle wait: addr=0x203, data=0x000000AB, ready after 3 cycles -> mem_be=1000, mem_wdata=0xAB000000; StallM high 3 cycles, then RESP for 1 cycle and back to IDLE.
- LB / LBU / LH from rdata=0x80F17F85:
  - LB addr[1:0]=00 -> 0xFFFFFF85.
  - LBU addr[1:0]=00 -> 0x00000085.
  - LH addr[1:0]=10 -> 0xFFFF80F1.
- Timeout: LW with mem_ready held 0 and TIMEOUT_CYCLES=16 -> mem_req drops after 16 WAIT cycles; BusErrM=1 and ReadDataM=0 in the RESP cycle.
- Reset mid-WAIT: reset_n=0 in the 2nd WAIT cycle -> mem_req=0 and StallM=0 immediately; after release the unit is in IDLE and a subsequent zero-wait LW completes normally.
- Misaligned LW at addr 0x102:
  - With MISALIGN_TRAP_EN: MisalignM=1 for 1 cycle, no mem_req.
  - Without it: mem_addr=0x100 and the access completes normally.
